clk_rst_sequencer: RTL
======================

CLK_RST_SEQUENCER -- requirements
Module: clk_rst_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYC, default 16: iclk cycles pll_rst is held high per attempt (min 2).
REQ-002 SHALL have parameter LOCK_STABLE_CYC, default 1024: consecutive cycles locked must stay high before release (min 1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYC, default 65536: per-attempt cycle limit from pll_rst low to release.
REQ-004 SHALL have parameter MAX_RETRY, default 3: failed attempts tolerated before fault (1..15).
REQ-005 iclk  input  1  reference clock; all logic except REQ-021 runs on its rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-low.
REQ-007 clk_pix  input  1  pixel clock from the PLL; stops while unlocked.
REQ-008 locked  input  1  PLL lock, asynchronous to iclk.
REQ-009 sw_restart  input  1  single-cycle iclk-synchronous restart request.
REQ-010 pll_rst  output  1  active-high PLL reset.
REQ-011 sys_rst_n  output  1  iclk-domain system reset, active-low, registered.
REQ-012 pix_rst_n  output  1  clk_pix-domain reset, active-low.
REQ-013 ready  output  1  high only in S_RUN.
REQ-014 fault  output  1  high only in S_FAULT.
REQ-015 retry_cnt  output  4  failed attempts in current sequence.
REQ-016 loss_cnt  output  8  lock-loss events in S_RUN since RST, saturating at 255.

Function
REQ-017 locked SHALL pass through a 2-flop iclk synchronizer (locked_s) before any use.
REQ-018 FSM states S_PLLRST, S_WAIT, S_STABLE, S_RUN, S_FAULT; one cycle counter and one timeout counter, both cleared on every state entry except as noted.
REQ-019 S_PLLRST: pll_rst=1 for exactly PLL_RST_CYC cycles, then -> S_WAIT with timeout counter cleared.
REQ-020 S_WAIT: pll_rst=0; locked_s=1 -> S_STABLE; timeout counter runs.
REQ-021 pix_rst_n SHALL assert asynchronously whenever sys_rst_n=0 or RST=0 and deassert after 2 clk_pix rising edges (async-assert/sync-release).
REQ-022 S_STABLE: counts cycles with locked_s=1; locked_s=0 -> S_WAIT with stable count cleared, timeout counter NOT cleared; count reaching LOCK_STABLE_CYC -> S_RUN.
REQ-023 Timeout counter reaching LOCK_TIMEOUT_CYC in S_WAIT or S_STABLE SHALL increment retry_cnt; new value < MAX_RETRY -> S_PLLRST, else -> S_FAULT.
REQ-024 S_RUN: sys_rst_n=1, ready=1, retry_cnt cleared on entry; locked_s=0 -> S_PLLRST, loss_cnt+1 (saturating), sys_rst_n low on the next iclk edge.
REQ-025 S_FAULT: pll_rst=1, sys_rst_n=0, fault=1; exited only by sw_restart or RST.
REQ-026 sys_rst_n SHALL be 0 in every state except S_RUN.
REQ-027 Latency: sys_rst_n rises exactly LOCK_STABLE_CYC+3 iclk edges after a locked rising edge seen in S_WAIT, locked held high.
REQ-028 sw_restart in any state -> S_PLLRST, retry_cnt=0, fault cleared next cycle; loss_cnt unchanged.
REQ-029 Priority on same cycle: sw_restart > stable completion > timeout > lock loss.
REQ-030 loss_cnt SHALL hold at 255 on further losses.

Reset
REQ-031 RST low SHALL asynchronously force S_PLLRST, counters 0, pll_rst=1, sys_rst_n=0, pix_rst_n=0, ready=0, fault=0, retry_cnt=0, loss_cnt=0, synchronizer flops 0.
REQ-032 RST high SHALL start a full sequence at S_PLLRST; RST low mid-sequence aborts it with no residual state.

Verification (bench params PLL_RST_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2)
REQ-033 Release RST, locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst_n and ready rise 11 edges after locked; pix_rst_n rises 2 clk_pix edges later.
REQ-034 locked glitches low 1 cycle at stable count 5 -> stays in reset; release 11 edges after re-rise, retry_cnt=0.
REQ-035 locked never rises -> retry_cnt 1 after 32 cycles, second pll_rst pulse, retry_cnt 2, fault=1, pll_rst=1 held.
REQ-036 In S_RUN drop locked -> sys_rst_n low within 3 edges, pix_rst_n low asynchronously, loss_cnt=1, new 4-cycle pll_rst pulse; 256 losses -> loss_cnt=255.
REQ-037 In S_FAULT pulse sw_restart -> fault=0, retry_cnt=0, new sequence; sw_restart on a timeout cycle -> S_PLLRST, retry_cnt=0.
REQ-038 RST low during S_STABLE -> all outputs at REQ-031 values immediately, no clock required.

Source files
------------

// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: PLL reset / lock-qualification sequencer producing iclk and clk_pix domain resets.
// Ports:
//   iclk, RST        reference clock, async active-low reset
//   clk_pix          PLL output clock (may stop while unlocked)
//   locked           PLL lock, asynchronous to iclk
//   sw_restart       one-cycle request to restart the sequence from S_PLLRST
//   pll_rst          active-high PLL reset (S_PLLRST and S_FAULT)
//   sys_rst_n        registered iclk-domain reset, released only in S_RUN
//   pix_rst_n        clk_pix-domain reset, async assert / 2-edge sync release
//   ready, fault     S_RUN / S_FAULT indicators
//   retry_cnt        failed lock attempts in the current sequence
//   loss_cnt         lock losses seen in S_RUN, saturating at 255
module clk_rst_sequencer #(
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 3
) (
  input  logic       iclk,
  input  logic       RST,
  input  logic       clk_pix,
  input  logic       locked,
  input  logic       sw_restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pix_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);
  localparam int CMAX = PLL_RST_CYC > LOCK_STABLE_CYC ? PLL_RST_CYC : LOCK_STABLE_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam logic [2:0] S_PLLRST = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0] retry_q, retry_d, retry_inc;
  logic [7:0] loss_q, loss_d;
  logic meta_q, locked_s_q, sys_q, sys_d, timeout;
  logic [1:0] pix_q;
  logic pix_arst_n;
  assign timeout   = tmo_q == TW'(LOCK_TIMEOUT_CYC - 1);
  assign retry_inc = retry_q + 4'd1;
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      S_PLLRST: state_d = cnt_q == CW'(PLL_RST_CYC - 1) ? S_WAIT : S_PLLRST;
      S_WAIT:
        if (timeout) begin
          retry_d = retry_inc;
          state_d = int'(retry_inc) < MAX_RETRY ? S_PLLRST : S_FAULT;
        end else if (locked_s_q) state_d = S_STABLE;
      S_STABLE:
        // completion outranks a coincident timeout
        if (locked_s_q && cnt_q == CW'(LOCK_STABLE_CYC - 1)) begin
          state_d = S_RUN;
          retry_d = 4'd0;
        end else if (timeout) begin
          retry_d = retry_inc;
          state_d = int'(retry_inc) < MAX_RETRY ? S_PLLRST : S_FAULT;
        end else if (!locked_s_q) state_d = S_WAIT;
      S_RUN:
        if (!locked_s_q) begin
          state_d = S_PLLRST;
          loss_d  = loss_q == 8'hff ? loss_q : loss_q + 8'd1;
        end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_PLLRST;
    endcase
    if (sw_restart) begin
      state_d = S_PLLRST;
      retry_d = 4'd0;
      loss_d  = loss_q;
    end
  end
  // cycle counter restarts on every state entry (a restart re-enters S_PLLRST);
  // the timeout counter spans the whole attempt across WAIT<->STABLE bounces
  assign cnt_d = (state_d != state_q || sw_restart) ? '0 : cnt_q + CW'(1);
  assign tmo_d = ((state_q == S_WAIT || state_q == S_STABLE) &&
                  (state_d == S_WAIT || state_d == S_STABLE)) ? tmo_q + TW'(1) : '0;
  assign sys_d = state_d == S_RUN;
  always_ff @(posedge iclk or negedge RST) begin
    if (!RST) begin
      state_q    <= S_PLLRST;
      cnt_q      <= '0;
      tmo_q      <= '0;
      retry_q    <= 4'd0;
      loss_q     <= 8'd0;
      meta_q     <= 1'b0;
      locked_s_q <= 1'b0;
      sys_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      meta_q     <= locked;
      locked_s_q <= meta_q;
      sys_q      <= sys_d;
    end
  end
  // pixel reset asserts without needing clk_pix, which may be stopped
  assign pix_arst_n = RST & sys_q;
  always_ff @(posedge clk_pix or negedge pix_arst_n) begin
    if (!pix_arst_n) pix_q <= 2'b00;
    else pix_q <= {pix_q[0], 1'b1};
  end
  assign pll_rst   = state_q == S_PLLRST || state_q == S_FAULT;
  assign ready     = state_q == S_RUN;
  assign fault     = state_q == S_FAULT;
  assign sys_rst_n = sys_q;
  assign pix_rst_n = pix_q[1];
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
endmodule
